// File: rtl/div_disp_pkg.sv
// rtl/div_disp_pkg.sv - shared FSM states, segment patterns and BCD helpers for div_result_display
package div_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_Q = 2'd1,
    ST_CONV_R = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // One double-dabble step: correct each digit >= 5, then shift the next operand bit in.
  function automatic logic [7:0] dd_step(input logic [7:0] acc, input logic bit_in);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
    units = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
    return {tens[2:0], units, bit_in};
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// rtl/seg7_enc.sv - combinational BCD digit to active-low 7-segment encoder with blanking
module seg7_enc
  import div_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg_lookup(digit);

endmodule

// File: rtl/div_result_display.sv
// rtl/div_result_display.sv - converts a quotient/remainder pair to BCD and drives four 7-segment displays
module div_result_display
  import div_disp_pkg::*;
#(
  parameter int Q_WIDTH = 4,
  parameter int R_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Q_WIDTH-1:0] quo,
  input  logic [R_WIDTH-1:0] rem,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic               done
);

  localparam logic [2:0] Q_LAST = 3'(Q_WIDTH - 1);
  localparam logic [2:0] R_LAST = 3'(R_WIDTH - 1);

  state_t             state;
  logic [7:0]         acc;
  logic [7:0]         q_bcd;
  logic [Q_WIDTH-1:0] q_sh;
  logic [R_WIDTH-1:0] r_sh;
  logic [2:0]         cnt;

  logic [7:0] q_step;
  logic [7:0] r_step;
  logic [6:0] q_units_seg;
  logic [6:0] q_tens_seg;
  logic [6:0] r_units_seg;
  logic [6:0] r_tens_seg;

  assign q_step = dd_step(acc, q_sh[Q_WIDTH-1]);
  assign r_step = dd_step(acc, r_sh[R_WIDTH-1]);

  // Quotient digits come from the saved BCD, remainder digits straight from the accumulator.
  seg7_enc u_q_units (.digit(q_bcd[3:0]), .blank(1'b0),               .seg(q_units_seg));
  seg7_enc u_q_tens  (.digit(q_bcd[7:4]), .blank(q_bcd[7:4] == 4'd0), .seg(q_tens_seg));
  seg7_enc u_r_units (.digit(acc[3:0]),   .blank(1'b0),               .seg(r_units_seg));
  seg7_enc u_r_tens  (.digit(acc[7:4]),   .blank(acc[7:4] == 4'd0),   .seg(r_tens_seg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      done     <= 1'b0;
      hex0     <= SEG_BLANK;
      hex1     <= SEG_BLANK;
      hex2     <= SEG_BLANK;
      hex3     <= SEG_BLANK;
      acc      <= '0;
      q_bcd    <= '0;
      q_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            q_sh     <= quo;
            r_sh     <= rem;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_CONV_Q;
          end
        end
        ST_CONV_Q: begin
          q_sh <= q_sh << 1;
          if (cnt == Q_LAST) begin
            q_bcd <= q_step;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_CONV_R;
          end else begin
            acc <= q_step;
            cnt <= cnt + 3'd1;
          end
        end
        ST_CONV_R: begin
          r_sh <= r_sh << 1;
          acc  <= r_step;
          if (cnt == R_LAST) begin
            cnt   <= '0;
            state <= ST_UPDATE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_UPDATE: begin
          hex0     <= q_units_seg;
          hex1     <= q_tens_seg;
          hex2     <= r_units_seg;
          hex3     <= r_tens_seg;
          done     <= 1'b1;
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_display.sv
// tb/tb_div_result_display.sv - scoreboard bench for div_result_display (default and Q_WIDTH=6 instances)
module tb_div_result_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid_a, in_ready_a, done_a;
  logic [3:0] quo_a, rem_a;
  logic [6:0] hex0_a, hex1_a, hex2_a, hex3_a;

  logic       in_valid_b, in_ready_b, done_b;
  logic [5:0] quo_b;
  logic [3:0] rem_b;
  logic [6:0] hex0_b, hex1_b, hex2_b, hex3_b;

  div_result_display dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .quo(quo_a), .rem(rem_a), .hex0(hex0_a), .hex1(hex1_a), .hex2(hex2_a),
    .hex3(hex3_a), .done(done_a)
  );

  div_result_display #(.Q_WIDTH(6), .R_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .quo(quo_b), .rem(rem_b), .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b),
    .hex3(hex3_b), .done(done_b)
  );

  typedef struct packed {
    logic [6:0] h3;
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
  } hexset_t;

  localparam hexset_t ALL_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

  hexset_t exp_q[$];
  hexset_t last_shown = ALL_BLANK;
  hexset_t mon_e;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int done_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic hexset_t exp_of(input int q, input int r);
    hexset_t e;
    e.h0 = seg_exp(q % 10);
    e.h1 = (q / 10 == 0) ? 7'h7F : seg_exp(q / 10);
    e.h2 = seg_exp(r % 10);
    e.h3 = (r / 10 == 0) ? 7'h7F : seg_exp(r / 10);
    return e;
  endfunction

  // Scoreboard: every done pulse on the default instance pops one expected display set.
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_hex0", 32'(hex0_a), 32'(mon_e.h0));
        check("sb_hex1", 32'(hex1_a), 32'(mon_e.h1));
        check("sb_hex2", 32'(hex2_a), 32'(mon_e.h2));
        check("sb_hex3", 32'(hex3_a), 32'(mon_e.h3));
        last_shown = mon_e;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_a), 32'd1);
    check({tag, "_done"},     32'(done_a),     32'd0);
    check({tag, "_hex0"},     32'(hex0_a),     32'h7F);
    check({tag, "_hex1"},     32'(hex1_a),     32'h7F);
    check({tag, "_hex2"},     32'(hex2_a),     32'h7F);
    check({tag, "_hex3"},     32'(hex3_a),     32'h7F);
  endtask

  // Called at a negedge with the block idle; transfer happens on the next rising edge.
  task automatic send_a(input int q, input int r);
    int n;
    check("ready_before_xfer", 32'(in_ready_a), 32'd1);
    in_valid_a = 1'b1;
    quo_a = 4'(q);
    rem_a = 4'(r);
    exp_q.push_back(exp_of(q, r));
    @(negedge clk);
    in_valid_a = 1'b0;
    quo_a = ~4'(q);
    rem_a = ~4'(r);
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 4) begin
        check("hold_hex0", 32'(hex0_a), 32'(last_shown.h0));
        check("hold_hex3", 32'(hex3_a), 32'(last_shown.h3));
      end
    end
    check("latency", 32'(n), 32'd9);
    check("ready_with_done", 32'(in_ready_a), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done_a), 32'd0);
  endtask

  initial begin
    int d0, w, n, prev_cyc;
    rst_n = 1'b0;
    in_valid_a = 1'b0; quo_a = '0; rem_a = '0;
    in_valid_b = 1'b0; quo_b = '0; rem_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    send_a(13, 2);
    send_a(0, 0);
    send_a(15, 9);
    send_a(10, 10);

    // Back-to-back with in_valid held high and an incrementing quotient
    d0 = done_cnt;
    prev_cyc = 0;
    in_valid_a = 1'b1;
    quo_a = 4'd0;
    rem_a = 4'd1;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (!in_ready_a && w < 30) begin
        @(negedge clk);
        w++;
      end
      check("b2b_ready", 32'(in_ready_a), 32'd1);
      exp_q.push_back(exp_of(int'(quo_a), int'(rem_a)));
      if (k > 0) check("b2b_gap", 32'(cyc - prev_cyc), 32'd10);
      prev_cyc = cyc;
      @(posedge clk);
      #1;
      quo_a = quo_a + 4'd1;
      if (k == 4) in_valid_a = 1'b0;
    end
    w = 0;
    while (!done_a && w < 30) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd5);

    // in_valid pulsed while busy must not start a second conversion
    d0 = done_cnt;
    in_valid_a = 1'b1; quo_a = 4'd5; rem_a = 4'd3;
    exp_q.push_back(exp_of(5, 3));
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (2) @(negedge clk);
    in_valid_a = 1'b1; quo_a = 4'd9; rem_a = 4'd9;
    repeat (3) @(negedge clk);
    in_valid_a = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted mid-conversion discards the pair
    d0 = done_cnt;
    in_valid_a = 1'b1; quo_a = 4'd7; rem_a = 4'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    last_shown = ALL_BLANK;
    repeat (15) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    send_a(8, 6);

    // Wide quotient instance
    in_valid_b = 1'b1; quo_b = 6'd63; rem_b = 4'd7;
    @(negedge clk);
    in_valid_b = 1'b0;
    n = 0;
    while (!done_b && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("w6_latency", 32'(n), 32'd11);
    check("w6_hex0", 32'(hex0_b), 32'(exp_of(63, 7).h0));
    check("w6_hex1", 32'(hex1_b), 32'(exp_of(63, 7).h1));
    check("w6_hex2", 32'(hex2_b), 32'(exp_of(63, 7).h2));
    check("w6_hex3", 32'(hex3_b), 32'(exp_of(63, 7).h3));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
